// File: rtl/matrix_serializer_pkg.sv
// Shared types and width helpers for matrix_serializer.
// The header build option is controlled by MATRIX_SERIALIZER_HEADER_EN (see matrix_serializer.sv).
package matrix_serializer_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_READY = 2'd2,
      S_SEND  = 2'd3
   } state_e;

   function automatic int syms_f(input int ew, input int ow);
      return ew / ow;
   endfunction

   function automatic int idx_w_f(input int rows, input int cols);
      return (rows * cols > 1) ? $clog2(rows * cols) : 1;
   endfunction

   // One spare bit so count/total can hold N plus header slots without wrapping.
   function automatic int cnt_w_f(input int rows, input int cols);
      return $clog2(rows * cols + 1) + 1;
   endfunction

   function automatic int phase_w_f(input int syms);
      return (syms > 1) ? $clog2(syms) : 1;
   endfunction

endpackage

// File: rtl/matrix_store_ram.sv
// Simple dual-port element store: one write port, one read port with a two-stage registered output.
module matrix_store_ram #(
   parameter int DW    = 8,
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rd1_q;
   logic [DW-1:0] rd2_q;

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rd1_q <= mem[raddr];
      rd2_q <= rd1_q;
   end

   assign rdata = rd2_q;

endmodule

// File: rtl/matrix_serializer.sv
// Collects a run-time sized matrix by (row, col) and streams it row-major as MSB-first symbols.
// Define MATRIX_SERIALIZER_HEADER_EN to prefix the stream with rows/cols header elements.
module matrix_serializer
   import matrix_serializer_pkg::*;
#(
   parameter int ELEMENT_WIDTH = 8,
   parameter int MAX_ROWS      = 32,
   parameter int MAX_COLS      = 32,
   parameter int OUT_WIDTH     = 2
) (
   input  logic                          eth_refclk,
   input  logic                          rst_n,
   input  logic [$clog2(MAX_ROWS+1)-1:0] cfg_rows,
   input  logic [$clog2(MAX_COLS+1)-1:0] cfg_cols,
   input  logic                          valid_data_in,
   input  logic [$clog2(MAX_ROWS)-1:0]   row_addr,
   input  logic [$clog2(MAX_COLS)-1:0]   col_addr,
   input  logic [ELEMENT_WIDTH-1:0]      matrix_element,
   input  logic                          data_request,
   output logic                          compile_done,
   output logic [OUT_WIDTH-1:0]          sym_out,
   output logic                          valid_data_out,
   output logic                          tx_done,
   output logic                          dup_write,
   output logic                          addr_error
);

   localparam int EW    = ELEMENT_WIDTH;
   localparam int SYMS  = syms_f(ELEMENT_WIDTH, OUT_WIDTH);
   localparam int CELLS = MAX_ROWS * MAX_COLS;
   localparam int RW    = $clog2(MAX_ROWS + 1);
   localparam int CW    = $clog2(MAX_COLS + 1);
   localparam int IW    = idx_w_f(MAX_ROWS, MAX_COLS);
   localparam int NW    = cnt_w_f(MAX_ROWS, MAX_COLS);
   localparam int PW    = phase_w_f(SYMS);

   state_e           state_q, state_d;
   logic [RW-1:0]    rows_q, rows_d;
   logic [CW-1:0]    cols_q, cols_d;
   logic [NW-1:0]    cnt_q, cnt_d;
   logic [CELLS-1:0] tracker_q, tracker_d;
   logic [NW-1:0]    rd_idx_q, rd_idx_d;
   logic [PW-1:0]    rd_phase_q, rd_phase_d;
   logic             pv1_q, pv2_q;
   logic [1:0]       pk1_q, pk2_q;
   logic [EW-1:0]    sh_q, sh_d;
   logic [PW-1:0]    rem_q, rem_d;
   logic [OUT_WIDTH-1:0] sym_q, sym_d;
   logic             valid_q, valid_d;
   logic             tx_done_q, tx_done_d;
   logic             dup_q, dup_d;
   logic             aerr_q, aerr_d;
   logic             cdone_q, cdone_d;

   logic [RW-1:0]    eff_rows_s;
   logic [CW-1:0]    eff_cols_s;
   logic             cfg_ok_s, wr_ok_s, rd_issue_s;
   logic [IW-1:0]    idx_s;
   logic [NW-1:0]    n_s, tot_s;
   logic [1:0]       kind_s;
   logic [EW-1:0]    rd_data_s, ld_data_s;

   // kind_s tags each read slot: 0 = RAM element, 1 = rows header, 2 = cols header.
`ifdef MATRIX_SERIALIZER_HEADER_EN
   localparam int HDR = 2;
   assign kind_s = (rd_idx_q == NW'(0)) ? 2'd1 : ((rd_idx_q == NW'(1)) ? 2'd2 : 2'd0);
`else
   localparam int HDR = 0;
   assign kind_s = 2'd0;
`endif

   // cfg is taken live in IDLE and from the latched copy once loading has begun.
   assign eff_rows_s = (state_q == S_IDLE) ? cfg_rows : rows_q;
   assign eff_cols_s = (state_q == S_IDLE) ? cfg_cols : cols_q;
   assign cfg_ok_s   = (eff_rows_s != RW'(0)) && (eff_rows_s <= RW'(MAX_ROWS)) &&
                       (eff_cols_s != CW'(0)) && (eff_cols_s <= CW'(MAX_COLS));
   assign wr_ok_s    = valid_data_in && cfg_ok_s &&
                       ((state_q == S_IDLE) || (state_q == S_LOAD)) &&
                       (RW'(row_addr) < eff_rows_s) && (CW'(col_addr) < eff_cols_s);
   assign idx_s      = IW'(row_addr) * IW'(eff_cols_s) + IW'(col_addr);
   assign n_s        = NW'(eff_rows_s) * NW'(eff_cols_s);
   assign tot_s      = NW'(rows_q) * NW'(cols_q) + NW'(HDR);

   matrix_store_ram #(
      .DW    (EW),
      .DEPTH (CELLS),
      .AW    (IW)
   ) u_ram (
      .clk   (eth_refclk),
      .we    (wr_ok_s),
      .waddr (idx_s),
      .wdata (matrix_element),
      .re    (rd_issue_s),
      .raddr (IW'(rd_idx_q - NW'(HDR))),
      .rdata (rd_data_s)
   );

   // FSM, cell tracker, unique count and read scheduling.
   always_comb begin
      state_d    = state_q;
      rows_d     = rows_q;
      cols_d     = cols_q;
      cnt_d      = cnt_q;
      tracker_d  = tracker_q;
      rd_idx_d   = rd_idx_q;
      rd_phase_d = rd_phase_q;
      rd_issue_s = 1'b0;
      dup_d      = 1'b0;
      aerr_d     = valid_data_in && !wr_ok_s;
      cdone_d    = (state_q == S_READY);
      tx_done_d  = 1'b0;
      case (state_q)
         S_IDLE, S_LOAD: begin
            if (wr_ok_s) begin
               if (state_q == S_IDLE) begin
                  rows_d = cfg_rows;
                  cols_d = cfg_cols;
               end
               tracker_d[idx_s] = 1'b1;
               if (tracker_q[idx_s]) dup_d = 1'b1;
               else                  cnt_d = cnt_q + NW'(1);
               state_d = (cnt_d == n_s) ? S_READY : S_LOAD;
            end
         end
         S_READY: begin
            if (data_request) begin
               state_d    = S_SEND;
               rd_idx_d   = NW'(0);
               rd_phase_d = PW'(0);
            end
         end
         S_SEND: begin
            rd_issue_s = (rd_phase_q == PW'(0)) && (rd_idx_q < tot_s);
            if (rd_phase_q == PW'(SYMS - 1)) begin
               rd_phase_d = PW'(0);
               rd_idx_d   = rd_idx_q + NW'(1);
            end else begin
               rd_phase_d = rd_phase_q + PW'(1);
            end
            // Last symbol is on the wire and nothing is queued behind it.
            if (valid_q && (rem_q == PW'(0)) && !pv2_q) begin
               state_d   = S_IDLE;
               tracker_d = '0;
               cnt_d     = NW'(0);
               tx_done_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Element loader and MSB-first shifter; loads land exactly as the previous element drains.
   always_comb begin
      case (pk2_q)
         2'd1:    ld_data_s = EW'(rows_q);
         2'd2:    ld_data_s = EW'(cols_q);
         default: ld_data_s = rd_data_s;
      endcase
      sh_d    = sh_q;
      rem_d   = rem_q;
      sym_d   = sym_q;
      valid_d = valid_q;
      if (pv2_q) begin
         sym_d   = ld_data_s[EW-1 -: OUT_WIDTH];
         sh_d    = ld_data_s << OUT_WIDTH;
         rem_d   = PW'(SYMS - 1);
         valid_d = 1'b1;
      end else if (valid_q && (rem_q != PW'(0))) begin
         sym_d   = sh_q[EW-1 -: OUT_WIDTH];
         sh_d    = sh_q << OUT_WIDTH;
         rem_d   = rem_q - PW'(1);
      end else begin
         sym_d   = '0;
         valid_d = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge eth_refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rows_q     <= '0;
         cols_q     <= '0;
         cnt_q      <= '0;
         tracker_q  <= '0;
         rd_idx_q   <= '0;
         rd_phase_q <= '0;
         pv1_q      <= 1'b0;
         pv2_q      <= 1'b0;
         pk1_q      <= 2'd0;
         pk2_q      <= 2'd0;
         sh_q       <= '0;
         rem_q      <= '0;
         sym_q      <= '0;
         valid_q    <= 1'b0;
         tx_done_q  <= 1'b0;
         dup_q      <= 1'b0;
         aerr_q     <= 1'b0;
         cdone_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         rows_q     <= rows_d;
         cols_q     <= cols_d;
         cnt_q      <= cnt_d;
         tracker_q  <= tracker_d;
         rd_idx_q   <= rd_idx_d;
         rd_phase_q <= rd_phase_d;
         pv1_q      <= rd_issue_s;
         pv2_q      <= pv1_q;
         pk1_q      <= kind_s;
         pk2_q      <= pk1_q;
         sh_q       <= sh_d;
         rem_q      <= rem_d;
         sym_q      <= sym_d;
         valid_q    <= valid_d;
         tx_done_q  <= tx_done_d;
         dup_q      <= dup_d;
         aerr_q     <= aerr_d;
         cdone_q    <= cdone_d;
      end
   end

   assign compile_done   = cdone_q;
   assign sym_out        = sym_q;
   assign valid_data_out = valid_q;
   assign tx_done        = tx_done_q;
   assign dup_write      = dup_q;
   assign addr_error     = aerr_q;

endmodule

// File: tb/tb_matrix_serializer.sv
// Directed scoreboard bench for matrix_serializer (default geometry 32x32, 8-bit elements, 2-bit symbols).
module tb_matrix_serializer;

`ifdef MATRIX_SERIALIZER_HEADER_EN
   localparam int HDR = 2;
`else
   localparam int HDR = 0;
`endif

   logic       eth_refclk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] cfg_rows = 6'd0;
   logic [5:0] cfg_cols = 6'd0;
   logic       valid_data_in = 1'b0;
   logic [4:0] row_addr = 5'd0;
   logic [4:0] col_addr = 5'd0;
   logic [7:0] matrix_element = 8'd0;
   logic       data_request = 1'b0;
   logic       compile_done;
   logic [1:0] sym_out;
   logic       valid_data_out;
   logic       tx_done;
   logic       dup_write;
   logic       addr_error;

   logic [7:0] model [32][32];
   logic [1:0] exp_q [$];
   int tests = 0;
   int fails = 0;

   always #5 eth_refclk = ~eth_refclk;

   matrix_serializer dut (
      .eth_refclk     (eth_refclk),
      .rst_n          (rst_n),
      .cfg_rows       (cfg_rows),
      .cfg_cols       (cfg_cols),
      .valid_data_in  (valid_data_in),
      .row_addr       (row_addr),
      .col_addr       (col_addr),
      .matrix_element (matrix_element),
      .data_request   (data_request),
      .compile_done   (compile_done),
      .sym_out        (sym_out),
      .valid_data_out (valid_data_out),
      .tx_done        (tx_done),
      .dup_write      (dup_write),
      .addr_error     (addr_error)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int r, input int c, input logic [7:0] v,
                     input logic exp_dup, input logic exp_err, input string tag);
      valid_data_in  = 1'b1;
      row_addr       = 5'(r);
      col_addr       = 5'(c);
      matrix_element = v;
      @(negedge eth_refclk);
      valid_data_in = 1'b0;
      chk({tag, "_dup"}, 32'(dup_write), 32'(exp_dup));
      chk({tag, "_err"}, 32'(addr_error), 32'(exp_err));
      if (!exp_err) model[r % 32][c % 32] = v;
   endtask

   task automatic load_all(input int rows, input int cols, input int seed, input string tag);
      cfg_rows = 6'(rows);
      cfg_cols = 6'(cols);
      for (int r = 0; r < rows; r++)
         for (int c = 0; c < cols; c++)
            wr(r, c, 8'(r * 11 + c * 7 + seed), 1'b0, 1'b0, tag);
      @(negedge eth_refclk);
      chk({tag, "_cdone"}, 32'(compile_done), 32'd1);
   endtask

   task automatic push_elem(input logic [7:0] v);
      logic [7:0] t;
      t = v;
      for (int s = 0; s < 4; s++) begin
         exp_q.push_back(t[7:6]);
         t = t << 2;
      end
   endtask

   task automatic push_matrix(input int rows, input int cols);
      if (HDR != 0) begin
         push_elem(8'(rows));
         push_elem(8'(cols));
      end
      for (int r = 0; r < rows; r++)
         for (int c = 0; c < cols; c++)
            push_elem(model[r][c]);
   endtask

   // Requests the stream and checks latency, symbol content, length and tx_done placement.
   task automatic stream(input string tag, input int nsym);
      int k, first, cnt, done_k;
      logic [1:0] e;
      data_request = 1'b1;
      @(negedge eth_refclk);
      data_request = 1'b0;
      k = 1; first = -1; cnt = 0; done_k = -1;
      chk({tag, "_cdone_hold"}, 32'(compile_done), 32'd1);
      while (k <= nsym + 12) begin
         if (k == 2) chk({tag, "_cdone_fall"}, 32'(compile_done), 32'd0);
         if (valid_data_out) begin
            if (first < 0) first = k;
            cnt++;
            chk({tag, "_sym_avail"}, 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk({tag, "_sym"}, 32'(sym_out), 32'(e));
            end
         end
         if (tx_done && done_k < 0) done_k = k;
         @(negedge eth_refclk);
         k++;
      end
      chk({tag, "_latency"}, 32'(first), 32'd4);
      chk({tag, "_valid_len"}, 32'(cnt), 32'(nsym));
      chk({tag, "_tx_done_at"}, 32'(done_k), 32'(first + nsym));
      chk({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      repeat (2) @(negedge eth_refclk);
      chk("rst_cdone", 32'(compile_done), 32'd0);
      chk("rst_valid", 32'(valid_data_out), 32'd0);
      chk("rst_sym", 32'(sym_out), 32'd0);
      chk("rst_txdone", 32'(tx_done), 32'd0);
      chk("rst_dup", 32'(dup_write), 32'd0);
      chk("rst_aerr", 32'(addr_error), 32'd0);
      rst_n = 1'b1;
      @(negedge eth_refclk);

      // 2x3 written in reverse order, (0,0) = 0xB4
      cfg_rows = 6'd2;
      cfg_cols = 6'd3;
      for (int i = 5; i >= 0; i--) begin
         wr(i / 3, i % 3, (i == 0) ? 8'hB4 : 8'(8'h30 + i), 1'b0, 1'b0, "rev");
         if (i == 1) chk("rev_cdone_early", 32'(compile_done), 32'd0);
      end
      @(negedge eth_refclk);
      chk("rev_cdone", 32'(compile_done), 32'd1);
      push_matrix(2, 3);
      stream("rev", (6 + HDR) * 4);

      // duplicate write to (1,2): 0x11 then 0x22
      wr(0, 0, 8'h5A, 1'b0, 1'b0, "dup_a");
      wr(0, 1, 8'h3C, 1'b0, 1'b0, "dup_b");
      wr(0, 2, 8'hC3, 1'b0, 1'b0, "dup_c");
      wr(1, 0, 8'h96, 1'b0, 1'b0, "dup_d");
      wr(1, 2, 8'h11, 1'b0, 1'b0, "dup_e");
      wr(1, 2, 8'h22, 1'b1, 1'b0, "dup_f");
      @(negedge eth_refclk);
      chk("dup_cdone_early", 32'(compile_done), 32'd0);
      wr(1, 1, 8'h0F, 1'b0, 1'b0, "dup_g");
      @(negedge eth_refclk);
      chk("dup_cdone", 32'(compile_done), 32'd1);
      chk("dup_model", 32'(model[1][2]), 32'h22);
      push_matrix(2, 3);
      stream("dup", (6 + HDR) * 4);

      // dropped writes: zero cfg, oversize cfg, row out of range, write while READY
      cfg_rows = 6'd0;
      wr(0, 0, 8'hEE, 1'b0, 1'b1, "cfg_zero");
      cfg_rows = 6'd33;
      wr(0, 0, 8'hEE, 1'b0, 1'b1, "cfg_big");
      cfg_rows = 6'd2;
      wr(0, 0, 8'h81, 1'b0, 1'b0, "oor_a");
      wr(0, 1, 8'h42, 1'b0, 1'b0, "oor_b");
      wr(2, 0, 8'hEE, 1'b0, 1'b1, "oor_row");
      wr(0, 2, 8'h24, 1'b0, 1'b0, "oor_c");
      wr(1, 0, 8'h18, 1'b0, 1'b0, "oor_d");
      wr(1, 1, 8'hE7, 1'b0, 1'b0, "oor_e");
      @(negedge eth_refclk);
      chk("oor_cdone_early", 32'(compile_done), 32'd0);
      wr(1, 2, 8'h7E, 1'b0, 1'b0, "oor_f");
      @(negedge eth_refclk);
      chk("oor_cdone", 32'(compile_done), 32'd1);
      wr(0, 0, 8'hFF, 1'b0, 1'b1, "ready_wr");
      push_matrix(2, 3);
      stream("oor", (6 + HDR) * 4);

      // two back-to-back full-size loads and streams
      load_all(32, 32, 3, "full1");
      push_matrix(32, 32);
      stream("full1", (1024 + HDR) * 4);
      load_all(32, 32, 101, "full2");
      push_matrix(32, 32);
      stream("full2", (1024 + HDR) * 4);

      // reset in the middle of a stream, then a fresh load
      load_all(2, 3, 55, "mid");
      data_request = 1'b1;
      @(negedge eth_refclk);
      data_request = 1'b0;
      repeat (8) @(negedge eth_refclk);
      chk("mid_streaming", 32'(valid_data_out), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(valid_data_out), 32'd0);
      chk("mid_rst_sym", 32'(sym_out), 32'd0);
      chk("mid_rst_cdone", 32'(compile_done), 32'd0);
      chk("mid_rst_txdone", 32'(tx_done), 32'd0);
      @(negedge eth_refclk);
      rst_n = 1'b1;
      exp_q.delete();
      @(negedge eth_refclk);
      load_all(3, 2, 77, "post");
      push_matrix(3, 2);
      stream("post", (6 + HDR) * 4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
